data_mem_responder: RTL and testbench

- Synthesizable responder for the core's data memory port: the memory end of the req/gnt/rvalid protocol that the core issues as initiator.
- Accepts loads and stores, applies byte enables to an internal word array, and returns in-order responses after a fixed latency.
- A bench-controlled grant stall and a backdoor preload port let the verification environment shape traffic and initialise memory.
- Sits beside the core wrapper in the testbench top, in place of the function-driven data_rdata_i path.

---
 rtl/data_mem_pkg.sv | 30 +++
 rtl/data_mem_responder_delay_line.sv | 32 +++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package data_mem_pkg;

    // One response travelling from the grant edge to the bus.
    typedef struct packed {
        logic        valid;
        logic        is_store;
        logic [31:0] rdata;
    } resp_t;

    // Read data returned when the word index falls outside the array.
    localparam logic [31:0] OOR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Replace each byte lane of old_word whose enable is set with the new lane.
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_responder_delay_line.sv
// Fixed-latency shift register carrying responses from grant to bus.
module mem_resp_delay_line
    import data_mem_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  resp_t in_i,
    output resp_t out_o
);

    resp_t stage_q [LATENCY];

    // Shift one stage per clock; reset discards everything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // The last stage is the response that goes onto the bus at the next edge.
    assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/data_mem_responder.sv
// Memory end of the core's req/gnt/rvalid data port: byte-enabled word
// array, in-order fixed-latency responses, grant throttling and a backdoor.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int          MEM_WORDS       = 1024,
    parameter int          LATENCY         = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] OOR_DATA        = OOR_DATA_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         data_req_i,
    output logic                         data_gnt_o,
    output logic                         data_rvalid_o,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [31:0]                  data_addr_i,
    input  logic [31:0]                  data_wdata_i,
    output logic [31:0]                  data_rdata_o,
    input  logic                         gnt_stall_i,
    input  logic                         ld_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr_i,
    input  logic [31:0]                  ld_wdata_i,
    output logic [15:0]                  rd_cnt_o,
    output logic [15:0]                  wr_cnt_o
);

    localparam int         IDX_W     = $clog2(MEM_WORDS);
    localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUTSTANDING);

    logic [31:0]      mem_q [MEM_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic             gnt;
    logic [1:0]       unused_addr_bits;

    logic [2:0]       outstanding_q, outstanding_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [15:0]      rd_cnt_q, rd_cnt_d;
    logic [15:0]      wr_cnt_q, wr_cnt_d;

    resp_t            resp_in;
    resp_t            resp_out;

    // Byte offset within the word has no meaning for a word-wide array.
    assign unused_addr_bits = data_addr_i[1:0];

    assign word_idx = data_addr_i[IDX_W+1:2];
    assign in_range = (data_addr_i[31:IDX_W+2] == '0);

    // Backdoor writes and the outstanding limit both hold the bus off.
    assign gnt = data_req_i & ~rst_i & ~gnt_stall_i & ~ld_we_i
               & (outstanding_q < MAX_OUT_C);

    // Build the response at the grant edge; loads sample the pre-write word.
    always_comb begin
        resp_in          = '0;
        resp_in.valid    = gnt;
        resp_in.is_store = data_we_i;
        if (gnt && !data_we_i) begin
            resp_in.rdata = in_range ? mem_q[word_idx] : OOR_DATA;
        end
    end

    // Word array: backdoor has absolute priority, otherwise granted stores.
    always_ff @(posedge clk_i) begin
        if (ld_we_i) begin
            mem_q[ld_addr_i] <= ld_wdata_i;
        end else if (gnt && data_we_i && in_range) begin
            mem_q[word_idx] <= be_merge(mem_q[word_idx], data_wdata_i, data_be_i);
        end
    end

    mem_resp_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay_line (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (resp_in),
        .out_o (resp_out)
    );

    // Issue the response leaving the delay line and track outstanding/counters.
    always_comb begin
        rvalid_d      = resp_out.valid;
        rdata_d       = rdata_q;
        rd_cnt_d      = rd_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        outstanding_d = outstanding_q;

        if (resp_out.valid) begin
            rdata_d = resp_out.rdata;
            if (resp_out.is_store) begin
                if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end
            end else begin
                if (rd_cnt_q != 16'hFFFF) begin
                    rd_cnt_d = rd_cnt_q + 16'd1;
                end
            end
        end

        case ({gnt, resp_out.valid})
            2'b10:   outstanding_d = outstanding_q + 3'd1;
            2'b01:   outstanding_d = outstanding_q - 3'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Response and bookkeeping registers; memory is intentionally not reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            outstanding_q <= '0;
        end else begin
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rd_cnt_q      <= rd_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign rd_cnt_o      = rd_cnt_q;
    assign wr_cnt_o      = wr_cnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded random and directed test of the data-memory responder.
module tb_data_mem_responder;

    localparam int          MEM_WORDS = 1024;
    localparam int          LATENCY   = 4;
    localparam int          MAX_OUT   = 2;
    localparam logic [31:0] OOR_WORD  = 32'hDEAD_BEEF;

    localparam int SEL_GNT   = 0;
    localparam int SEL_RDATA = 1;
    localparam int SEL_RDCNT = 2;
    localparam int SEL_WRCNT = 3;

    typedef struct {
        int unsigned due;
        logic        isStore;
        logic [31:0] data;
    } expT;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } dirT;

    logic        clk;
    logic        rst;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        ldWe;
    logic [9:0]  ldAddr;
    logic [31:0] ldData;
    logic [15:0] rdCnt;
    logic [15:0] wrCnt;

    logic [31:0] modelMem [MEM_WORDS];
    expT         pending [$];
    dirT         dirQ [$];
    int unsigned edgeCount;
    int          checks;
    int          errors;
    logic [15:0] modelRd;
    logic [15:0] modelWr;
    logic [31:0] modelLast;

    data_mem_responder #(
        .MEM_WORDS       (MEM_WORDS),
        .LATENCY         (LATENCY),
        .MAX_OUTSTANDING (MAX_OUT),
        .OOR_DATA        (OOR_WORD)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_req_i    (req),
        .data_gnt_o    (gnt),
        .data_rvalid_o (rvalid),
        .data_we_i     (we),
        .data_be_i     (be),
        .data_addr_i   (addr),
        .data_wdata_i  (wdata),
        .data_rdata_o  (rdata),
        .gnt_stall_i   (stall),
        .ld_we_i       (ldWe),
        .ld_addr_i     (ldAddr),
        .ld_wdata_i    (ldData),
        .rd_cnt_o      (rdCnt),
        .wr_cnt_o      (wrCnt)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: at each edge decide the grant from the rules, update
    // the word array and schedule the response LATENCY edges later.
    always @(posedge clk or posedge rst) begin
        expT         e;
        logic [31:0] wordNum;
        logic [31:0] mask;
        if (rst) begin
            pending.delete();
        end else begin
            edgeCount = edgeCount + 1;
            if (ldWe) begin
                modelMem[ldAddr] = ldData;
            end
            if (req && !stall && !ldWe && pending.size() < MAX_OUT) begin
                wordNum   = addr >> 2;
                e.due     = edgeCount + LATENCY;
                e.isStore = we;
                if (we) begin
                    e.data = 32'h0;
                    if (wordNum < 32'(MEM_WORDS)) begin
                        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                        modelMem[wordNum[9:0]] = (modelMem[wordNum[9:0]] & ~mask) | (wdata & mask);
                    end
                end else begin
                    e.data = (wordNum < 32'(MEM_WORDS)) ? modelMem[wordNum[9:0]] : OOR_WORD;
                end
                pending.push_back(e);
            end
        end
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h at edge %0d", name, act, exp, edgeCount);
        end
    endtask

    // Monitor: away from the active edge, retire due responses from the
    // scoreboard and compare everything the DUT presents.
    always @(negedge clk) begin
        expT  e;
        dirT  d;
        logic expGnt;
        logic [31:0] act;
        if (rst) begin
            modelRd   = '0;
            modelWr   = '0;
            modelLast = '0;
            compare("rvalidInReset", {31'b0, rvalid}, 32'h0);
            compare("rdataInReset", rdata, 32'h0);
        end else if (pending.size() > 0 && pending[0].due <= edgeCount) begin
            e = pending.pop_front();
            compare("rvalidDue", {31'b0, rvalid}, 32'h1);
            compare("rdata", rdata, e.data);
            modelLast = e.data;
            if (e.isStore) begin
                if (modelWr != 16'hFFFF) modelWr = modelWr + 16'd1;
            end else begin
                if (modelRd != 16'hFFFF) modelRd = modelRd + 16'd1;
            end
        end else begin
            compare("rvalidIdle", {31'b0, rvalid}, 32'h0);
            compare("rdataHold", rdata, modelLast);
        end
        expGnt = req && !rst && !stall && !ldWe && (pending.size() < MAX_OUT);
        compare("gnt", {31'b0, gnt}, {31'b0, expGnt});
        compare("rdCnt", {16'b0, rdCnt}, {16'b0, modelRd});
        compare("wrCnt", {16'b0, wrCnt}, {16'b0, modelWr});
        while (dirQ.size() > 0) begin
            d = dirQ.pop_front();
            case (d.sel)
                SEL_GNT:   act = {31'b0, gnt};
                SEL_RDATA: act = rdata;
                SEL_RDCNT: act = {16'b0, rdCnt};
                default:   act = {16'b0, wrCnt};
            endcase
            compare(d.name, act, d.exp);
        end
    end

    // Queue a directed expectation, checked at the next sampling point.
    task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
        dirT d;
        d.name = name;
        d.sel  = sel;
        d.exp  = exp;
        dirQ.push_back(d);
    endtask

    // Drive all inputs for one cycle, then move to just after the next edge.
    task automatic applyStimulus(
        input logic        rstV,
        input logic        reqV,
        input logic        weV,
        input logic [3:0]  beV,
        input logic [31:0] addrV,
        input logic [31:0] wdataV,
        input logic        stallV,
        input logic        ldWeV,
        input logic [9:0]  ldAddrV,
        input logic [31:0] ldDataV
    );
        rst    = rstV;
        req    = reqV;
        we     = weV;
        be     = beV;
        addr   = addrV;
        wdata  = wdataV;
        stall  = stallV;
        ldWe   = ldWeV;
        ldAddr = ldAddrV;
        ldData = ldDataV;
        @(posedge clk);
        #1;
    endtask

    task automatic busCycle(input logic weV, input logic [3:0] beV,
                            input logic [31:0] addrV, input logic [31:0] wdataV);
        applyStimulus(1'b0, 1'b1, weV, beV, addrV, wdataV, 1'b0, 1'b0, 10'd0, 32'h0);
    endtask

    task automatic backdoorWrite(input logic [9:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, a, d);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
        end
    endtask

    // Directed scenarios followed by constrained-random traffic.
    initial begin
        logic [31:0] word0;
        logic        heldPattern [4];
        logic        rReq, rWe, rStall, rLdWe;
        logic [3:0]  rBe;
        logic [31:0] rAddr;
        int          sel;

        checks    = 0;
        errors    = 0;
        edgeCount = 0;
        modelRd   = '0;
        modelWr   = '0;
        modelLast = '0;
        heldPattern[0] = 1'b1;
        heldPattern[1] = 1'b1;
        heldPattern[2] = 1'b0;
        heldPattern[3] = 1'b0;

        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
        stall = 1'b0; ldWe = 1'b0; ldAddr = '0; ldData = '0;
        @(posedge clk);
        #1;
        checkOutput("gntDuringReset", SEL_GNT, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
        checkOutput("rdCntAfterReset", SEL_RDCNT, 32'h0);
        checkOutput("rdataAfterReset", SEL_RDATA, 32'h0);
        idleCycles(1);

        $display("[TB] preloading memory");
        for (int i = 0; i < MEM_WORDS; i++) begin
            backdoorWrite(10'(i), $urandom);
        end
        backdoorWrite(10'd5, 32'h1234_5678);
        backdoorWrite(10'd3, 32'hAABB_CCDD);

        $display("[TB] basic load");
        busCycle(1'b0, 4'h0, 32'h14, 32'h0);
        idleCycles(6);
        checkOutput("loadWord5", SEL_RDATA, 32'h1234_5678);
        checkOutput("rdCntOne", SEL_RDCNT, 32'h1);
        idleCycles(1);

        $display("[TB] byte-enabled store then load");
        busCycle(1'b1, 4'b0101, 32'h0C, 32'h1122_3344);
        idleCycles(6);
        checkOutput("storeRespZero", SEL_RDATA, 32'h0);
        checkOutput("wrCntOne", SEL_WRCNT, 32'h1);
        busCycle(1'b0, 4'h0, 32'h0C, 32'h0);
        idleCycles(6);
        checkOutput("beMerged", SEL_RDATA, 32'hAA22_CC44);
        idleCycles(1);

        $display("[TB] outstanding limit");
        for (int k = 0; k < 4; k++) begin
            checkOutput("heldReqGnt", SEL_GNT, {31'b0, heldPattern[k]});
            busCycle(1'b0, 4'h0, 32'h20, 32'h0);
        end
        idleCycles(10);

        $display("[TB] grant stall");
        for (int k = 0; k < 3; k++) begin
            checkOutput("stalledGnt", SEL_GNT, 32'h0);
            applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0, 1'b1, 1'b0, 10'd0, 32'h0);
        end
        checkOutput("gntAfterStall", SEL_GNT, 32'h1);
        busCycle(1'b0, 4'h0, 32'h24, 32'h0);
        idleCycles(8);

        $display("[TB] out-of-range access");
        busCycle(1'b0, 4'h0, 32'h0001_0000, 32'h0);
        idleCycles(6);
        checkOutput("oorLoad", SEL_RDATA, OOR_WORD);
        idleCycles(1);
        word0 = modelMem[0];
        busCycle(1'b1, 4'hF, 32'h0001_0000, 32'h0BAD_F00D);
        busCycle(1'b0, 4'h0, 32'h0, 32'h0);
        idleCycles(6);
        checkOutput("oorStoreDropped", SEL_RDATA, word0);
        idleCycles(1);

        $display("[TB] reset with a load in flight");
        checkOutput("gntBeforeReset", SEL_GNT, 32'h1);
        busCycle(1'b0, 4'h0, 32'h14, 32'h0);
        checkOutput("gntInMidReset", SEL_GNT, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
        idleCycles(8);
        checkOutput("rdCntCleared", SEL_RDCNT, 32'h0);
        checkOutput("wrCntCleared", SEL_WRCNT, 32'h0);
        idleCycles(1);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            rReq   = ($urandom_range(0, 1) == 1);
            rWe    = ($urandom_range(0, 1) == 1);
            rBe    = 4'($urandom_range(0, 15));
            rStall = ($urandom_range(0, 7) == 0);
            rLdWe  = ($urandom_range(0, 15) == 0);
            sel    = $urandom_range(0, 15);
            if (sel == 0) begin
                rAddr = $urandom;
                if (rAddr < 32'h1000) rAddr = rAddr | 32'h0001_0000;
            end else if (sel < 8) begin
                rAddr = {20'b0, 10'($urandom_range(0, MEM_WORDS - 1)), 2'($urandom_range(0, 3))};
            end else begin
                rAddr = {20'b0, 10'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            end
            applyStimulus(1'b0, rReq, rWe, rBe, rAddr, $urandom, rStall, rLdWe,
                          10'($urandom_range(0, 15)), $urandom);
        end
        idleCycles(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
